spi_mem_master: RTL

SPI master that serves every memory access of the rv32e CPU core: instruction fetches, loads and stores. It sits directly downstream of the CPU control FSM, takes one level-held request at a time, and runs a single-lane SPI mode-0 transaction to one of two external chips: flash on cs1 for the lower half of the address space, PSRAM on cs2 for the upper half. Read data is returned as a raw MSB-first shift image; the CPU performs byte reordering and sign extension.

---
 rtl/spi_mem_master_pkg.sv | 13 +
 rtl/spi_shift_engine.sv | 73 +++++++
 rtl/spi_mem_master.sv | 80 ++++++++
 3 files changed

// File: rtl/spi_mem_master_pkg.sv
// spi_mem_master_pkg: SPI command codes, frame sizing, FSM states and byte-count clamp
package spi_mem_master_pkg;
    localparam logic [7:0] READ_CMD  = 8'h03;
    localparam logic [7:0] WRITE_CMD = 8'h02;
    localparam int MAX_BYTES = 4;
    localparam int FRAME_W   = 32 + 8 * MAX_BYTES;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    function automatic logic [2:0] clamp_bytes(input logic [2:0] n);
        return (n > 3'(MAX_BYTES)) ? 3'(MAX_BYTES) : n;
    endfunction
endpackage

// File: rtl/spi_shift_engine.sv
// spi_shift_engine: mode-0 bit engine, one SPI bit per two clocks, MSB-first TX, RX into a 32-bit image
//   i_load/i_frame/i_length : start a frame of i_length bits taken from i_frame MSB-first
//   i_rx_en                 : capture miso during the data phase (clears the image on load)
//   o_busy                  : low from the high phase of the last bit onward
//   o_active                : chip select window; o_sclk/o_mosi : SPI pins; o_rx : read image
module spi_shift_engine
    import spi_mem_master_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic [FRAME_W-1:0] i_frame,
    input  logic [6:0]         i_length,
    input  logic               i_rx_en,
    input  logic               i_miso,
    output logic               o_busy,
    output logic               o_active,
    output logic               o_sclk,
    output logic               o_mosi,
    output logic [31:0]        o_rx
);
    logic [FRAME_W-1:0] r_tx;
    logic [6:0]         r_cnt;
    logic [6:0]         r_dbits;
    logic [31:0]        r_rx;
    logic               r_arm, r_run, r_sclk, r_rd;
    logic               w_last;

    // r_cnt holds bits remaining including the current one; data bits are the last r_dbits
    assign w_last   = r_run & r_sclk & (r_cnt == 7'd1);
    assign o_busy   = r_arm | (r_run & ~w_last);
    assign o_active = r_run;
    assign o_sclk   = r_sclk;
    assign o_mosi   = r_run & r_tx[FRAME_W-1];
    assign o_rx     = r_rx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx    <= '0;
            r_cnt   <= '0;
            r_dbits <= '0;
            r_rx    <= '0;
            r_arm   <= 1'b0;
            r_run   <= 1'b0;
            r_sclk  <= 1'b0;
            r_rd    <= 1'b0;
        end else if (i_load) begin
            r_tx    <= i_frame;
            r_cnt   <= i_length;
            r_dbits <= i_length - 7'd32;
            r_arm   <= 1'b1;
            r_run   <= 1'b0;
            r_sclk  <= 1'b0;
            r_rd    <= i_rx_en;
            if (i_rx_en)
                r_rx <= '0;
        end else if (r_arm) begin
            // one cycle gap so chip select falls one edge after the request is taken
            r_arm <= 1'b0;
            r_run <= 1'b1;
        end else if (r_run) begin
            r_sclk <= ~r_sclk;
            if (r_sclk) begin
                r_tx  <= r_tx << 1;
                r_cnt <= r_cnt - 7'd1;
                if (r_cnt == 7'd1)
                    r_run <= 1'b0;
                if (r_rd && r_cnt <= r_dbits)
                    r_rx <= {r_rx[30:0], i_miso};
            end
        end
    end
endmodule

// File: rtl/spi_mem_master.sv
// spi_mem_master: CPU memory port to single-lane SPI flash (cs1, low half) and PSRAM (cs2, high half)
//   start_request/is_write/num_bytes/target_address/write_value : level-held CPU request
//   fetched_value : raw MSB-first read image; request_done : held until start_request drops
//   sclk/mosi/miso/cs1/cs2 : SPI mode-0 pins
module spi_mem_master
    import spi_mem_master_pkg::*;
#(
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_request,
    input  logic              is_write,
    input  logic [2:0]        num_bytes,
    input  logic [ADDR_W-1:0] target_address,
    input  logic [31:0]       write_value,
    output logic [31:0]       fetched_value,
    output logic              request_done,
    output logic              sclk,
    output logic              mosi,
    output logic              cs1,
    output logic              cs2,
    input  logic              miso
);
    state_t             r_state, w_next;
    logic               r_sel;
    logic [2:0]         w_n;
    logic [6:0]         w_len;
    logic [FRAME_W-1:0] w_frame;
    logic               w_load, w_busy, w_active;

    assign w_n   = clamp_bytes(num_bytes);
    assign w_len = 7'd32 + {1'b0, w_n, 3'b000};
    // store bytes go out low byte first; unsent tail bytes are simply never shifted
    assign w_frame = {is_write ? WRITE_CMD : READ_CMD,
                      24'(target_address[ADDR_W-2:0]),
                      is_write ? {write_value[7:0], write_value[15:8], write_value[23:16], write_value[31:24]} : 32'h0};
    assign w_load = (r_state == IDLE) && start_request && (w_n != 3'd0);

    spi_shift_engine u_engine (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_load),
        .i_frame  (w_frame),
        .i_length (w_len),
        .i_rx_en  (~is_write),
        .i_miso   (miso),
        .o_busy   (w_busy),
        .o_active (w_active),
        .o_sclk   (sclk),
        .o_mosi   (mosi),
        .o_rx     (fetched_value)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_sel   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && start_request)
                r_sel <= target_address[ADDR_W-1];
        end
    end

    // a no-op request passes through SHIFT with the engine idle, giving done one edge later
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = start_request ? SHIFT : IDLE;
            SHIFT:   w_next = w_busy ? SHIFT : DONE;
            DONE:    w_next = start_request ? DONE : IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign request_done = (r_state == DONE);
    assign cs1 = ~((r_state == SHIFT) & w_active & ~r_sel);
    assign cs2 = ~((r_state == SHIFT) & w_active & r_sel);
endmodule
